// File: rtl/instr_loader_if.sv
// ============================================================================
// instr_loader_if : byte-stream input and instruction-memory write bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_loader_if #(
  parameter int D_WIDTH   = 8,
  parameter int EXT_WIDTH = 32
);
  logic                 rx_valid;
  logic [D_WIDTH-1:0]   rx_data;
  logic                 rx_ready;
  logic                 WE;
  logic [EXT_WIDTH-1:0] WA;
  logic [D_WIDTH-1:0]   WD;

  // master = stream source / memory side, slave = loader
  modport master (output rx_valid, rx_data, input rx_ready, WE, WA, WD);
  modport slave  (input rx_valid, rx_data, output rx_ready, WE, WA, WD);
endinterface

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// instr_loader : parses a framed program image from a byte stream and writes
//                it into instruction memory at the reset vector region.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_loader #(
  parameter int                 D_WIDTH   = 8,
  parameter int                 EXT_WIDTH = 32,
  parameter logic [31:0]        BASE_ADDR = 32'hBFC00000,
  parameter int                 MEM_BYTES = 4096,
  parameter logic [D_WIDTH-1:0] SYNC      = 8'hA5
) (
  input  wire             clk,
  input  wire             rst_n,
  instr_loader_if.slave   bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [16:0] c_mem_bytes = 17'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          off_q, off_d;
  logic [D_WIDTH-1:0]   sum_q, sum_d;
  logic                 we_q, we_d;
  logic [EXT_WIDTH-1:0] wa_q, wa_d;
  logic [D_WIDTH-1:0]   wd_q, wd_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  wire                  w_xfer     = bus.rx_valid;
  wire  [15:0]          w_len_full = {bus.rx_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      off_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= EXT_WIDTH'(BASE_ADDR);
      wd_q    <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    if (w_xfer) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.rx_data == SYNC) begin
            state_d = S_LEN_LO;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            sum_d   = '0;
            off_d   = '0;
          end
        end
        S_LEN_LO: begin
          len_d   = {len_q[15:8], bus.rx_data};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = w_len_full;
          // Oversized images are rejected before any byte reaches memory
          if ({1'b0, w_len_full} > c_mem_bytes) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else if (w_len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          we_d  = 1'b1;
          wa_d  = EXT_WIDTH'(BASE_ADDR) + EXT_WIDTH'(off_q);
          wd_d  = bus.rx_data;
          sum_d = sum_q + bus.rx_data;
          off_d = off_q + 16'd1;
          if (off_q == len_q - 16'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          busy_d = 1'b0;
          if (bus.rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready = 1'b1;
  assign bus.WE       = we_q;
  assign bus.WA       = wa_q;
  assign bus.WD       = wd_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// tb_instr_loader : table vectors, reset corner cases and random frames
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_loader;

  localparam logic [31:0] c_base = 32'hBFC00000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold, busy, done, err;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  instr_loader_if bus ();

  instr_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tx_q[$];
  bit          pay_q[$];
  logic [7:0]  exp_q[$];
  int          acc_q[$];
  logic [31:0] got_wa_q[$];
  logic [7:0]  got_wd_q[$];
  int          got_t_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.WE === 1'b1) begin
      got_wa_q.push_back(bus.WA);
      got_wd_q.push_back(bus.WD);
      got_t_q.push_back(cyc);
    end
  end

  typedef struct {
    string       name;
    logic [95:0] bytes;
    int          n;
    int          ps;
    int          nwr;
    logic [31:0] wd;
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_all();
    tx_q.delete(); pay_q.delete(); exp_q.delete(); acc_q.delete();
    got_wa_q.delete(); got_wd_q.delete(); got_t_q.delete();
  endtask

  task automatic push(input logic [7:0] b, input bit p);
    tx_q.push_back(b);
    pay_q.push_back(p);
    if (p) exp_q.push_back(b);
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < tx_q.size(); i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = tx_q[i];
      @(posedge clk);
      #1;
      if (pay_q[i]) acc_q.push_back(cyc);
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(maxgap, 0)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_frame(input string nm, input logic ed, input logic ee, input logic eh);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_nwr"}, got_wd_q.size(), exp_q.size());
    for (int i = 0; i < got_wd_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_wa%0d", nm, i), got_wa_q[i], c_base + i);
      chk($sformatf("%s_wd%0d", nm, i), {24'd0, got_wd_q[i]}, {24'd0, exp_q[i]});
      if (i < acc_q.size())
        chk($sformatf("%s_lat%0d", nm, i), got_t_q[i], acc_q[i]);
    end
    chk({nm, "_done"}, {31'd0, done}, {31'd0, ed});
    chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
    chk({nm, "_hold"}, {31'd0, cpu_hold}, {31'd0, eh});
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_ready"}, {31'd0, bus.rx_ready}, 32'd1);
    clear_all();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_we"}, {31'd0, bus.WE}, 32'd0);
    chk({nm, "_wa"}, bus.WA, c_base);
    chk({nm, "_wd"}, {24'd0, bus.WD}, 32'd0);
    chk({nm, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_ready"}, {31'd0, bus.rx_ready}, 32'd1);
  endtask

  task automatic apply_vec(input int v);
    clear_all();
    for (int i = 0; i < vt[v].n; i++) begin
      tx_q.push_back(vt[v].bytes[95-8*i -: 8]);
      pay_q.push_back(i >= vt[v].ps && i < vt[v].ps + vt[v].nwr);
    end
    for (int j = 0; j < vt[v].nwr; j++) exp_q.push_back(vt[v].wd[31-8*j -: 8]);
    send_frame(1);
    check_frame(vt[v].name, vt[v].done, vt[v].err, vt[v].hold);
  endtask

  // Frame-level model: expected writes are the payload bytes in order from
  // the base address; the outcome depends only on length and checksum.
  task automatic build_random(output logic ed, output logic ee, output logic eh);
    logic [7:0]  b, sum;
    logic [15:0] len;
    bit          corrupt;
    clear_all();
    repeat ($urandom_range(3, 0)) begin
      b = 8'($urandom_range(255, 0));
      if (b == 8'hA5) b = 8'h00;
      push(b, 1'b0);
    end
    push(8'hA5, 1'b0);
    if ($urandom_range(7, 0) == 0) begin
      len = 16'($urandom_range(65535, 4097));
      push(len[7:0], 1'b0);
      push(len[15:8], 1'b0);
      ed = 1'b0; ee = 1'b1; eh = 1'b1;
    end else begin
      len = 16'($urandom_range(40, 0));
      push(len[7:0], 1'b0);
      push(len[15:8], 1'b0);
      sum = 8'd0;
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom_range(255, 0));
        push(b, 1'b1);
        sum = sum + b;
      end
      corrupt = ($urandom_range(3, 0) == 0);
      push(corrupt ? sum + 8'd1 : sum, 1'b0);
      ed = !corrupt; ee = corrupt; eh = corrupt;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ed, ee, eh;
    logic [7:0] s;
    vt[0] = '{"good",   96'hA5040013_00000013_00000000, 8, 3, 4, 32'h13000000, 1'b1, 1'b0, 1'b0};
    vt[1] = '{"badcs",  96'hA5040013_00000014_00000000, 8, 3, 4, 32'h13000000, 1'b0, 1'b1, 1'b1};
    vt[2] = '{"regood", 96'hA5040013_00000013_00000000, 8, 3, 4, 32'h13000000, 1'b1, 1'b0, 1'b0};
    vt[3] = '{"oversz", 96'hA5011000_00000000_00000000, 3, 3, 0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vt[4] = '{"len0",   96'hA5000000_00000000_00000000, 4, 3, 0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vt[5] = '{"len0bad",96'hA5000001_00000000_00000000, 4, 3, 0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vt[6] = '{"garbage",96'h00FF5AA5_0200A501_A6000000, 9, 6, 2, 32'hA5010000, 1'b1, 1'b0, 1'b0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_in");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("rst_out");

    for (int v = 0; v < 7; v++) apply_vec(v);

    // Reset while the second payload write is in flight
    clear_all();
    push(8'hA5, 1'b0); push(8'h04, 1'b0); push(8'h00, 1'b0);
    push(8'h11, 1'b1); push(8'h22, 1'b1);
    send_frame(0);
    chk("mid_we_pre", {31'd0, bus.WE}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    chk("mid_nwr", got_wd_q.size(), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_vec(0);

    // Largest accepted image fills memory exactly
    clear_all();
    push(8'hA5, 1'b0); push(8'h00, 1'b0); push(8'h10, 1'b0);
    s = 8'd0;
    for (int i = 0; i < 4096; i++) begin
      ed = 1'b0;
      tx_q.push_back(8'($urandom_range(255, 0)));
      pay_q.push_back(1'b1);
      exp_q.push_back(tx_q[tx_q.size()-1]);
      s = s + tx_q[tx_q.size()-1];
    end
    push(s, 1'b0);
    send_frame(0);
    check_frame("max", 1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      build_random(ed, ee, eh);
      send_frame(2);
      check_frame($sformatf("rnd%0d", f), ed, ee, eh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
